// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first Y = A - B - B_in, one bit per cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output OVF.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             B_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nx;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             bw_nx;
  logic             d;
  logic             last;
  logic             accept;

  // one full-subtractor cell on the operand LSBs
  assign d      = a_sr[0] ^ b_sr[0] ^ bw;
  assign bw_nx  = (~a_sr[0] & b_sr[0])
                | (~(a_sr[0] ^ b_sr[0]) & bw);
  assign r_nx   = {d, r_sr[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      bw    <= 1'b0;
      Y     <= '0;
      B_out <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      bw   <= B_in;
      cnt  <= '0;
    end else if (state_q == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nx;
      bw   <= bw_nx;
      cnt  <= cnt + CW'(1);
      // results land on the edge that enters DONE
      if (last) begin
        Y     <= r_nx;
        B_out <= bw_nx;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // borrow into the MSB cell vs. borrow out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OVF <= 1'b0;
    end else if (state_q == RUN && last) begin
      OVF <= bw ^ bw_nx;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, hand sequences and random ops
// checked against an arithmetic reference of A - B - B_in.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         B_in;
  logic         busy;
  logic         done;
  logic [W-1:0] Y;
  logic         B_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_done = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .B_in  (B_in),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .B_out (B_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] y;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_sub(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return 9'(r);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic bin);
    int s;
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (s < -128) || (s > 127);
  endfunction

  // Called at a negedge; returns at a negedge in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic bin, output logic [7:0] y,
                        output logic bo, output logic ov,
                        output int lat, output int nbusy,
                        output logic held);
    logic [7:0] y0;
    for (int k = 0; k < 20 && (busy || done); k++) @(negedge clk);
    y = 'x;
    bo = 'x;
    ov = 'x;
    lat = 0;
    nbusy = 0;
    held = 1'b1;
    y0 = Y;
    A = a;
    B = b;
    B_in = bin;
    start = 1'b1;
    @(posedge clk);
    n_starts++;
    #1;
    start = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    B_in = 1'($urandom);
    for (int k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        y = Y;
        bo = B_out;
`ifdef SERIAL_SUB_OVF_EN
        ov = ovf;
`else
        ov = 1'b0;
`endif
        n_done++;
        break;
      end
      if (busy) nbusy++;
      if (Y !== y0) held = 1'b0;
      start = 1'($urandom);
      A = 8'($urandom);
      B = 8'($urandom);
      B_in = 1'($urandom);
    end
    start = 1'b0;
    chk("done_seen", 32'(lat != 0), 32'd1);
    @(negedge clk);
    if (done) n_done++;
  endtask

  task automatic check_res(input string nm, input logic [7:0] a,
                           input logic [7:0] b, input logic bin,
                           input logic [7:0] y, input logic bo,
                           input logic ov);
    logic [8:0] e;
    e = ref_sub(a, b, bin);
    chk({nm, "_y"}, 32'(y), 32'(e[7:0]));
    chk({nm, "_bo"}, 32'(bo), 32'(e[8]));
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, 32'(ov), 32'(ref_ovf(a, b, bin)));
`else
    if (ov !== 1'b0) chk({nm, "_ovf"}, 32'(ov), 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] y;
    logic       bo;
    logic       ov;
    logic       held;
    logic       yhold;
    logic       seen;
    int         lat;
    int         nbusy;
    int         ndone;
    int         lastk;
    int         nd;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic [7:0] corner [6];

    tbl[0] = '{8'd100, 8'd58, 1'b0, 8'd42,  1'b0, 1'b0};
    tbl[1] = '{8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0};
    tbl[2] = '{8'd0,   8'd0,  1'b1, 8'hFF,  1'b1, 1'b0};
    tbl[3] = '{8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1};
    tbl[4] = '{8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1};
    tbl[5] = '{8'h10,  8'h20, 1'b0, 8'hF0,  1'b1, 1'b0};
    tbl[6] = '{8'h10,  8'h01, 1'b0, 8'h0F,  1'b0, 1'b0};
    tbl[7] = '{8'hFF,  8'h00, 1'b1, 8'hFE,  1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    B_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(Y), 32'd0);
    chk("rst_bo", 32'(B_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, y, bo, ov, lat, nbusy, held);
      chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_bo", i), 32'(bo), 32'(tbl[i].bo));
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(ov), 32'(tbl[i].ov));
`endif
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(W + 1));
      chk($sformatf("tbl%0d_busy", i), 32'(nbusy), 32'(W));
      chk($sformatf("tbl%0d_hold", i), 32'(held), 32'd1);
    end

    // start held high, A disturbed while running
    A = 8'h33;
    B = 8'h11;
    B_in = 1'b0;
    start = 1'b1;
    ndone = 0;
    lastk = -1;
    yhold = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 4 * (W + 2); k++) begin
      @(negedge clk);
      if (done) begin
        chk("cont_y", 32'(Y), 32'h22);
        chk("cont_bo", 32'(B_out), 32'd0);
        if (lastk >= 0) chk("cont_period", 32'(k - lastk), 32'(W + 2));
        lastk = k;
        ndone++;
        seen = 1'b1;
        A = 8'h33;
      end else begin
        if (seen && Y !== 8'h22) yhold = 1'b0;
        if (busy) A = 8'hFF;
      end
    end
    start = 1'b0;
    chk("cont_ndone", 32'(ndone), 32'd4);
    chk("cont_yhold", 32'(yhold), 32'd1);
    @(negedge clk);

    // asynchronous abort in the middle of a run
    A = 8'hAA;
    B = 8'h55;
    B_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(Y), 32'd0);
    chk("abort_bo", 32'(B_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_quiet", 32'(nd), 32'd0);
    run_op(8'h10, 8'h01, 1'b0, y, bo, ov, lat, nbusy, held);
    chk("post_abort_y", 32'(y), 32'h0F);
    chk("post_abort_bo", 32'(bo), 32'd0);

    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(corner[i], corner[j], 1'(c), y, bo, ov, lat, nbusy, held);
          check_res("corner", corner[i], corner[j], 1'(c), y, bo, ov);
        end
      end
    end

    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, y, bo, ov, lat, nbusy, held);
      check_res("rand", ra, rb, rbin, y, bo, ov);
      if (lat != W + 1) chk("rand_lat", 32'(lat), 32'(W + 1));
    end

    chk("done_count", 32'(n_done), 32'(n_starts));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
